// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: CPU-side controller in front of an 8-bit single-port block RAM.
// It decodes CPU requests against a 2**ADDR_WIDTH byte window at BASE_ADDR and
// sequences the RAM's one-cycle synchronous read latency. Each access completes
// with a one-cycle ack pulse. Out-of-window accesses never touch the RAM and
// complete with cpu_err.
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   cpu_req         request strobe, sampled only while idle
//   cpu_we          1 = write, 0 = read (sampled with cpu_req)
//   cpu_addr        CPU byte address (sampled with cpu_req)
//   cpu_wdata       write data (sampled with cpu_req)
//   cpu_ack         one-cycle completion pulse
//   cpu_rdata       read data, valid with cpu_ack on reads and held afterwards
//   cpu_err         pulses with cpu_ack for out-of-window accesses
//   cpu_busy        high while a request is in progress
//   mem_rd_enable   RAM read strobe
//   mem_wr_enable   RAM byte write enables (all set for a write)
//   mem_addr        RAM word address (window offset)
//   mem_wr_data     RAM write data
//   mem_rd_data     RAM read data, valid the cycle after the read strobe
module mem_bus_ctrl #(
   parameter int unsigned               DATA_WIDTH     = 8,
   parameter int unsigned               ADDR_WIDTH     = 12,
   parameter int unsigned               CPU_ADDR_WIDTH = 16,
   parameter logic [CPU_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
   parameter logic [DATA_WIDTH-1:0]     OPEN_BUS       = '1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cpu_req,
   input  logic                      cpu_we,
   input  logic [CPU_ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0]     cpu_wdata,
   output logic                      cpu_ack,
   output logic [DATA_WIDTH-1:0]     cpu_rdata,
   output logic                      cpu_err,
   output logic                      cpu_busy,
   output logic                      mem_rd_enable,
   output logic [3:0]                mem_wr_enable,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_wr_data,
   input  logic [DATA_WIDTH-1:0]     mem_rd_data
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   // Window size held one bit wider than the CPU bus so a full-bus window still fits.
   localparam logic [CPU_ADDR_WIDTH:0] WIN_SIZE = (CPU_ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

   state_t                    state;
   logic                      we_q;
   logic                      err_q;
   logic [CPU_ADDR_WIDTH-1:0] offset_c;
   logic                      in_window_c;

   // Offset wraps modulo the bus width, so addresses below BASE_ADDR land out of window.
   assign offset_c    = cpu_addr - BASE_ADDR;
   assign in_window_c = {1'b0, offset_c} < WIN_SIZE;

   // Request sequencer. RAM strobes are loaded on the edge entering ACCESS so the
   // RAM samples them at the end of ACCESS and its data is valid during CAPTURE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         we_q          <= 1'b0;
         err_q         <= 1'b0;
         cpu_ack       <= 1'b0;
         cpu_err       <= 1'b0;
         cpu_busy      <= 1'b0;
         cpu_rdata     <= '0;
         mem_rd_enable <= 1'b0;
         mem_wr_enable <= 4'h0;
         mem_addr      <= '0;
         mem_wr_data   <= '0;
      end else begin
         cpu_ack       <= 1'b0;
         cpu_err       <= 1'b0;
         mem_rd_enable <= 1'b0;
         mem_wr_enable <= 4'h0;

         case (state)
            IDLE: begin
               if (cpu_req) begin
                  we_q     <= cpu_we;
                  err_q    <= ~in_window_c;
                  cpu_busy <= 1'b1;
                  if (in_window_c) begin
                     mem_addr <= offset_c[ADDR_WIDTH-1:0];
                     if (cpu_we) begin
                        mem_wr_enable <= 4'hF;
                        mem_wr_data   <= cpu_wdata;
                     end else begin
                        mem_rd_enable <= 1'b1;
                     end
                     state <= ACCESS;
                  end else begin
                     state <= RESP;
                  end
               end
            end

            ACCESS: begin
               state <= we_q ? RESP : CAPTURE;
            end

            CAPTURE: begin
               cpu_rdata <= mem_rd_data;
               state     <= RESP;
            end

            RESP: begin
               cpu_ack  <= 1'b1;
               cpu_err  <= err_q;
               cpu_busy <= 1'b0;
               if (err_q && !we_q) begin
                  cpu_rdata <= OPEN_BUS;
               end
               state <= IDLE;
            end

            default: begin
               cpu_busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed bench for mem_bus_ctrl. Two instances share the
// clock, reset and request payload: one with the window at 0x0000 and one at
// 0xF000. Each instance has its own behavioural RAM with a one-cycle read.
module tb_mem_bus_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0 = 1'b1;
   logic        req1 = 1'b1;
   logic        cpu_we = 1'b0;
   logic [15:0] cpu_addr = 16'h0000;
   logic [7:0]  cpu_wdata = 8'h00;

   logic        ack0, err0, busy0, rd_en0;
   logic [7:0]  rdata0, mwd0, mrd0;
   logic [3:0]  wr_en0;
   logic [11:0] maddr0;

   logic        ack1, err1, busy1, rd_en1;
   logic [7:0]  rdata1, mwd1, mrd1;
   logic [3:0]  wr_en1;
   logic [11:0] maddr1;

   logic [7:0]  ram0 [4096];
   logic [7:0]  ram1 [4096];

   int rd_cnt0 = 0, wr_cnt0 = 0, rd_cnt1 = 0, wr_cnt1 = 0;
   logic [11:0] last_addr0 = '0, last_addr1 = '0;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   mem_bus_ctrl #(.BASE_ADDR(16'h0000), .OPEN_BUS(8'hFF)) dut0 (
      .clk(clk), .reset(reset), .cpu_req(req0), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(ack0),
      .cpu_rdata(rdata0), .cpu_err(err0), .cpu_busy(busy0),
      .mem_rd_enable(rd_en0), .mem_wr_enable(wr_en0), .mem_addr(maddr0),
      .mem_wr_data(mwd0), .mem_rd_data(mrd0)
   );

   mem_bus_ctrl #(.BASE_ADDR(16'hF000), .OPEN_BUS(8'hFF)) dut1 (
      .clk(clk), .reset(reset), .cpu_req(req1), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(ack1),
      .cpu_rdata(rdata1), .cpu_err(err1), .cpu_busy(busy1),
      .mem_rd_enable(rd_en1), .mem_wr_enable(wr_en1), .mem_addr(maddr1),
      .mem_wr_data(mwd1), .mem_rd_data(mrd1)
   );

   // RAM models plus strobe-cycle counters and last strobed address.
   always @(posedge clk) begin
      if (wr_en0 == 4'hF) ram0[maddr0] <= mwd0;
      if (rd_en0 == 1'b1) mrd0 <= ram0[maddr0];
      if (rd_en0 == 1'b1) rd_cnt0++;
      if (wr_en0 != 4'h0 && wr_en0 !== 4'hx) wr_cnt0++;
      if (rd_en0 == 1'b1 || wr_en0 == 4'hF) last_addr0 <= maddr0;

      if (wr_en1 == 4'hF) ram1[maddr1] <= mwd1;
      if (rd_en1 == 1'b1) mrd1 <= ram1[maddr1];
      if (rd_en1 == 1'b1) rd_cnt1++;
      if (wr_en1 != 4'h0 && wr_en1 !== 4'hx) wr_cnt1++;
      if (rd_en1 == 1'b1 || wr_en1 == 4'hF) last_addr1 <= maddr1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // One request on the selected instance; reports latency (edges from accept to
   // ack, 0 on timeout), read data and error flag, and checks the ack is one cycle.
   task automatic access(input int sel, input logic we, input logic [15:0] addr,
                         input logic [7:0] wd, output int lat,
                         output logic [7:0] rd, output logic err);
      logic a;
      @(negedge clk);
      cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
      if (sel == 0) req0 = 1'b1; else req1 = 1'b1;
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
      lat = 0; rd = '0; err = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         a = (sel == 0) ? ack0 : ack1;
         if (a) begin
            lat = i;
            rd  = (sel == 0) ? rdata0 : rdata1;
            err = (sel == 0) ? err0 : err1;
            break;
         end
      end
      if (lat == 0) check("ack_timeout", 32'(0), 32'(1));
      else begin
         @(posedge clk); #1;
         a = (sel == 0) ? ack0 : ack1;
         check("ack_one_cycle", 32'(a), 32'(0));
      end
   endtask

   initial begin
      int lat;
      logic [7:0] rd;
      logic err;
      int r0, w0, r1, w1;
      int acks, first_ack, second_ack, third_ack;

      // Reset held three cycles with requests asserted.
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack",   32'(ack0),   32'(0));
      check("rst_err",   32'(err0),   32'(0));
      check("rst_busy",  32'(busy0),  32'(0));
      check("rst_rdata", 32'(rdata0), 32'(0));
      check("rst_rd_en", 32'(rd_en0), 32'(0));
      check("rst_wr_en", 32'(wr_en0), 32'(0));
      check("rst_maddr", 32'(maddr0), 32'(0));
      check("rst_mwd",   32'(mwd0),   32'(0));
      check("rst_busy1", 32'(busy1),  32'(0));
      check("rst_strobes", 32'(rd_cnt0 + wr_cnt0 + rd_cnt1 + wr_cnt1), 32'(0));
      @(negedge clk);
      reset = 1'b0; req0 = 1'b0; req1 = 1'b0;

      // Write then read back in the 0x0000 window.
      r0 = rd_cnt0; w0 = wr_cnt0;
      access(0, 1'b1, 16'h0123, 8'hA5, lat, rd, err);
      check("wr_lat",    32'(lat), 32'(2));
      check("wr_err",    32'(err), 32'(0));
      check("wr_strobe", 32'(wr_cnt0 - w0), 32'(1));
      check("wr_no_rd",  32'(rd_cnt0 - r0), 32'(0));
      check("wr_maddr",  32'(last_addr0), 32'h123);
      r0 = rd_cnt0; w0 = wr_cnt0;
      access(0, 1'b0, 16'h0123, 8'h00, lat, rd, err);
      check("rd_lat",    32'(lat), 32'(3));
      check("rd_data",   32'(rd),  32'hA5);
      check("rd_err",    32'(err), 32'(0));
      check("rd_strobe", 32'(rd_cnt0 - r0), 32'(1));
      check("rd_no_wr",  32'(wr_cnt0 - w0), 32'(0));

      // Out-of-window read just past the window.
      r0 = rd_cnt0; w0 = wr_cnt0;
      access(0, 1'b0, 16'h1000, 8'h00, lat, rd, err);
      check("oow_lat",     32'(lat), 32'(1));
      check("oow_err",     32'(err), 32'(1));
      check("oow_rdata",   32'(rd),  32'hFF);
      check("oow_strobes", 32'((rd_cnt0 - r0) + (wr_cnt0 - w0)), 32'(0));

      // Window edges at base 0xF000.
      access(1, 1'b1, 16'hF000, 8'h3C, lat, rd, err);
      check("lo_wr_lat",   32'(lat), 32'(2));
      check("lo_wr_maddr", 32'(last_addr1), 32'h000);
      access(1, 1'b1, 16'hFFFF, 8'hC3, lat, rd, err);
      check("hi_wr_err",   32'(err), 32'(0));
      check("hi_wr_maddr", 32'(last_addr1), 32'hFFF);
      access(1, 1'b0, 16'hF000, 8'h00, lat, rd, err);
      check("lo_rd_data",  32'(rd), 32'h3C);
      check("lo_rd_maddr", 32'(last_addr1), 32'h000);
      access(1, 1'b0, 16'hFFFF, 8'h00, lat, rd, err);
      check("hi_rd_data",  32'(rd), 32'hC3);
      check("hi_rd_lat",   32'(lat), 32'(3));
      r1 = rd_cnt1; w1 = wr_cnt1;
      access(1, 1'b0, 16'hEFFF, 8'h00, lat, rd, err);
      check("below_err",   32'(err), 32'(1));
      check("below_lat",   32'(lat), 32'(1));
      check("below_rdata", 32'(rd),  32'hFF);
      // Write at 0x0000 wraps below the base: error, rdata kept at open-bus value.
      access(1, 1'b1, 16'h0000, 8'h77, lat, rd, err);
      check("wrap_wr_err",   32'(err), 32'(1));
      check("wrap_wr_rdata", 32'(rd),  32'hFF);
      check("edge_oow_strobes", 32'((rd_cnt1 - r1) + (wr_cnt1 - w1)), 32'(0));

      // Back-to-back reads with request held 12 cycles.
      access(0, 1'b1, 16'h0010, 8'h5A, lat, rd, err);
      r0 = rd_cnt0;
      acks = 0; first_ack = 0; second_ack = 0; third_ack = 0;
      @(negedge clk);
      cpu_we = 1'b0; cpu_addr = 16'h0010; req0 = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         if (c == 2) check("b2b_busy", 32'(busy0), 32'(1));
         if (ack0) begin
            acks++;
            if (acks == 1) first_ack = c;
            if (acks == 2) second_ack = c;
            if (acks == 3) third_ack = c;
            check("b2b_data", 32'(rdata0), 32'h5A);
         end
      end
      req0 = 1'b0;
      check("b2b_acks",    32'(acks), 32'(3));
      check("b2b_first",   32'(first_ack), 32'(4));
      check("b2b_space1",  32'(second_ack - first_ack), 32'(4));
      check("b2b_space2",  32'(third_ack - second_ack), 32'(4));
      check("b2b_strobes", 32'(rd_cnt0 - r0), 32'(3));

      // Reset asserted during the CAPTURE cycle of a read.
      @(negedge clk);
      cpu_we = 1'b0; cpu_addr = 16'h0123; req0 = 1'b1;
      @(posedge clk); #1;           // accepted, now ACCESS
      req0 = 1'b0;
      @(posedge clk); #1;           // now CAPTURE
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("mid_rst_busy",  32'(busy0),  32'(0));
      check("mid_rst_rd_en", 32'(rd_en0), 32'(0));
      check("mid_rst_rdata", 32'(rdata0), 32'(0));
      acks = 0;
      for (int c = 0; c < 5; c++) begin
         if (ack0) acks++;
         @(posedge clk); #1;
      end
      check("mid_rst_no_ack", 32'(acks), 32'(0));
      access(0, 1'b0, 16'h0123, 8'h00, lat, rd, err);
      check("post_rst_lat",  32'(lat), 32'(3));
      check("post_rst_data", 32'(rd),  32'hA5);
      check("post_rst_err",  32'(err), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
